// File: rtl/uart_tx_sched.sv
// Transmit scheduler: byte FIFO in front of a UART_TX serializer. It launches one
// frame at a time, follows the serializer's busy handshake and spaces frames by GAP.
module uart_tx_sched #(
   parameter int DEPTH   = 16,
   parameter int GAP     = 0,
   parameter int BUSY_TO = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   wr_valid_i,
   input  logic [7:0]             wr_data_i,
   output logic                   wr_ready_o,
   input  logic                   flush_i,
   input  logic                   enable_i,
   input  logic                   tx_busy_i,
   output logic                   tx_valid_o,
   output logic [7:0]             tx_data_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic                   overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_GAP       = 2'd3;
   // With no gap configured the end of a frame returns straight to IDLE.
   localparam logic [1:0] ST_AFTER     = (GAP == 0) ? ST_IDLE : ST_GAP;

   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TO - 1);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [LW-1:0] level_r;
   logic [LW-1:0] level_nxt_s;
   logic          empty_r;
   logic          full_r;
   logic          overflow_r;
   logic          wr_ready_s;
   logic          push_s;
   logic          launch_s;
   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic [BW-1:0] busy_cnt_r;
   logic [BW-1:0] busy_cnt_nxt_s;
   logic [GW-1:0] gap_cnt_r;
   logic [GW-1:0] gap_cnt_nxt_s;
   logic          tx_valid_r;
   logic [7:0]    tx_data_r;

   assign wr_ready_s = !full_r && !flush_i;
   assign push_s     = wr_valid_i && wr_ready_s;
   assign launch_s   = (state_r == ST_IDLE) && enable_i && !empty_r && !tx_busy_i;

   // Occupancy after this edge's push and pop
   always_comb begin
      level_nxt_s = level_r;
      case ({push_s, launch_s})
         2'b10:   level_nxt_s = level_r + LW'(1);
         2'b01:   level_nxt_s = level_r - LW'(1);
         default: level_nxt_s = level_r;
      endcase
   end

   // Storage array, written only on an accepted push
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data_i;
      end
   end

   // FIFO pointers, occupancy and status flags
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r   <= AW'(0);
         rd_ptr_r   <= AW'(0);
         level_r    <= LW'(0);
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (flush_i) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (launch_s) begin
               rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_nxt_s;
            empty_r <= (level_nxt_s == LW'(0));
            full_r  <= (level_nxt_s == LVL_FULL);
         end
         // A refused write wins over a simultaneous flush.
         if (wr_valid_i && !wr_ready_s) begin
            overflow_r <= 1'b1;
         end else if (flush_i) begin
            overflow_r <= 1'b0;
         end
      end
   end

   // Frame sequencing: launch, wait for busy, wait for done, idle gap
   always_comb begin
      state_nxt_s    = state_r;
      busy_cnt_nxt_s = busy_cnt_r;
      gap_cnt_nxt_s  = gap_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (launch_s) begin
               state_nxt_s    = ST_WAIT_BUSY;
               busy_cnt_nxt_s = BW'(0);
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT_BUSY: begin
            if (tx_busy_i) begin
               state_nxt_s = ST_WAIT_DONE;
            end else if (busy_cnt_r == BUSY_LAST) begin
               state_nxt_s   = ST_AFTER;
               gap_cnt_nxt_s = GAP_LOAD;
            end else begin
               busy_cnt_nxt_s = busy_cnt_r + BW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy_i) begin
               state_nxt_s   = ST_AFTER;
               gap_cnt_nxt_s = GAP_LOAD;
            end else begin
               state_nxt_s = ST_WAIT_DONE;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r <= GW'(1)) begin
               state_nxt_s   = ST_IDLE;
               gap_cnt_nxt_s = GW'(0);
            end else begin
               gap_cnt_nxt_s = gap_cnt_r - GW'(1);
            end
         end
         default: begin
            state_nxt_s    = ST_IDLE;
            busy_cnt_nxt_s = BW'(0);
            gap_cnt_nxt_s  = GW'(0);
         end
      endcase
   end

   // FSM state, counters and the registered launch outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= ST_IDLE;
         busy_cnt_r <= BW'(0);
         gap_cnt_r  <= GW'(0);
         tx_valid_r <= 1'b0;
         tx_data_r  <= 8'h00;
      end else begin
         state_r    <= state_nxt_s;
         busy_cnt_r <= busy_cnt_nxt_s;
         gap_cnt_r  <= gap_cnt_nxt_s;
         tx_valid_r <= launch_s;
         if (launch_s) begin
            tx_data_r <= mem_r[rd_ptr_r];
         end
      end
   end

   assign wr_ready_o = wr_ready_s;
   assign tx_valid_o = tx_valid_r;
   assign tx_data_o  = tx_data_r;
   assign level_o    = level_r;
   assign empty_o    = empty_r;
   assign full_o     = full_r;
   assign overflow_o = overflow_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: scoreboard of launched bytes plus a simple busy model.
module tb_uart_tx_sched;

   localparam int DEPTH   = 16;
   localparam int GAP     = 3;
   localparam int BUSY_TO = 4;
   localparam int LW      = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          wr_valid;
   logic [7:0]    wr_data;
   logic          wr_ready;
   logic          flush;
   logic          enable;
   logic          tx_busy;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic [LW-1:0] level;
   logic          empty;
   logic          full;
   logic          overflow;

   uart_tx_sched #(.DEPTH(DEPTH), .GAP(GAP), .BUSY_TO(BUSY_TO)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .wr_valid_i (wr_valid),
      .wr_data_i  (wr_data),
      .wr_ready_o (wr_ready),
      .flush_i    (flush),
      .enable_i   (enable),
      .tx_busy_i  (tx_busy),
      .tx_valid_o (tx_valid),
      .tx_data_o  (tx_data),
      .level_o    (level),
      .empty_o    (empty),
      .full_o     (full),
      .overflow_o (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         compared = 0;
   int         mismatched = 0;
   logic [7:0] exp_q[$];
   int         pulse_cnt = 0;
   int         last_valid_cyc = 0;
   int         prev_valid_cyc = 0;
   bit         busy_model = 1'b0;
   int         busy_left = 0;
   bit         start_pending = 1'b0;
   bit         have_fall = 1'b0;
   int         fall_cyc = 0;
   int         base;
   int         push_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // One clock: sample at the falling edge, run the busy model and the scoreboard.
   task automatic tick();
      logic [7:0] exp_b;
      @(negedge clk);
      if (busy_model) begin
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               tx_busy   = 1'b0;
               fall_cyc  = cyc;
               have_fall = 1'b1;
            end
         end else if (start_pending) begin
            tx_busy       = 1'b1;
            busy_left     = 100;
            start_pending = 1'b0;
         end
      end else begin
         tx_busy       = 1'b0;
         busy_left     = 0;
         start_pending = 1'b0;
      end
      if (tx_valid === 1'b1) begin
         pulse_cnt++;
         prev_valid_cyc = last_valid_cyc;
         last_valid_cyc = cyc;
         compared++;
         assert (exp_q.size() != 0) else begin
            mismatched++;
            $error("FAIL sb_unexpected: launch of 0x%0h with nothing queued", tx_data);
         end
         if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            chk("sb_data", {24'h0, tx_data}, {24'h0, exp_b});
         end
         if (busy_model && have_fall) begin
            chk("gap_spacing", cyc - fall_cyc, GAP + 2);
            have_fall = 1'b0;
         end
         if (busy_model) start_pending = 1'b1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      int n = 0;
      while (wr_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n == 100) chk("push_ready_wait", {31'h0, wr_ready}, 32'h1);
      wr_valid = 1'b1;
      wr_data  = b;
      if (wr_ready === 1'b1) exp_q.push_back(b);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_pulses(input int target, input int budget);
      int n = 0;
      while (pulse_cnt < target && n < budget) begin
         tick();
         n++;
      end
      chk("pulse_wait", pulse_cnt, target);
   endtask

   initial begin
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      flush    = 1'b0;
      enable   = 1'b0;
      tx_busy  = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_data", {24'h0, tx_data}, 32'h0);
      chk("rst_level", {27'h0, level}, 32'h0);
      chk("rst_empty", {31'h0, empty}, 32'h1);
      chk("rst_full", {31'h0, full}, 32'h0);
      chk("rst_ovf", {31'h0, overflow}, 32'h0);
      chk("rst_ready", {31'h0, wr_ready}, 32'h1);

      // Single byte: launch two edges after the push
      enable   = 1'b1;
      base     = pulse_cnt;
      push_cyc = cyc;
      push(8'hA5);
      chk("lat_e0_valid", {31'h0, tx_valid}, 32'h0);
      chk("lat_e0_level", {27'h0, level}, 32'h1);
      tick();
      chk("single_pulses", pulse_cnt - base, 1);
      chk("single_latency", last_valid_cyc - push_cyc, 2);
      chk("single_level", {27'h0, level}, 32'h0);
      chk("single_empty", {31'h0, empty}, 32'h1);
      repeat (12) tick();
      chk("single_once", pulse_cnt - base, 1);
      chk("single_hold", {24'h0, tx_data}, 32'hA5);

      // Busy never rises: timeout then gap, next byte still launches
      base = pulse_cnt;
      push(8'h55);
      push(8'h66);
      chk("pushpop_level", {27'h0, level}, 32'h1);
      wait_pulses(base + 2, 40);
      chk("timeout_spacing", last_valid_cyc - prev_valid_cyc, 1 + BUSY_TO + GAP);
      repeat (12) tick();

      // Burst with a modelled busy serializer
      enable     = 1'b0;
      busy_model = 1'b1;
      have_fall  = 1'b0;
      for (int i = 1; i <= 4; i++) push(8'(i));
      chk("burst_level", {27'h0, level}, 32'h4);
      base   = pulse_cnt;
      enable = 1'b1;
      wait_pulses(base + 4, 700);
      repeat (110) tick();
      chk("burst_busy_low", {31'h0, tx_busy}, 32'h0);
      busy_model = 1'b0;
      have_fall  = 1'b0;
      chk("burst_empty", {31'h0, empty}, 32'h1);

      // Full, overflow and flush
      enable = 1'b0;
      for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i));
      chk("full_flag", {31'h0, full}, 32'h1);
      chk("full_level", {27'h0, level}, 32'h10);
      chk("full_ready", {31'h0, wr_ready}, 32'h0);
      chk("full_ovf_clear", {31'h0, overflow}, 32'h0);
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      tick();
      wr_valid = 1'b0;
      chk("ovf_set", {31'h0, overflow}, 32'h1);
      chk("ovf_level", {27'h0, level}, 32'h10);
      flush    = 1'b1;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      exp_q.delete();
      chk("flushwr_ovf", {31'h0, overflow}, 32'h1);
      chk("flushwr_level", {27'h0, level}, 32'h0);
      tick();
      flush = 1'b0;
      chk("flush_ovf", {31'h0, overflow}, 32'h0);
      chk("flush_empty", {31'h0, empty}, 32'h1);
      chk("flush_full", {31'h0, full}, 32'h0);

      // Flush while the serializer is busy with a frame
      push(8'h11);
      push(8'h22);
      push(8'h33);
      busy_model = 1'b1;
      have_fall  = 1'b0;
      base       = pulse_cnt;
      enable     = 1'b1;
      wait_pulses(base + 1, 10);
      repeat (5) tick();
      chk("midframe_level", {27'h0, level}, 32'h2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      chk("midframe_flushed", {27'h0, level}, 32'h0);
      repeat (120) tick();
      chk("midframe_pulses", pulse_cnt - base, 1);
      busy_model = 1'b0;
      tick();
      have_fall = 1'b0;

      // Asynchronous reset during the gap
      base = pulse_cnt;
      push(8'h3C);
      push(8'h7E);
      wait_pulses(base + 1, 10);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("arst_data", {24'h0, tx_data}, 32'h0);
      chk("arst_valid", {31'h0, tx_valid}, 32'h0);
      chk("arst_level", {27'h0, level}, 32'h0);
      chk("arst_empty", {31'h0, empty}, 32'h1);
      chk("arst_ready", {31'h0, wr_ready}, 32'h1);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();

      // Forty bytes through the FIFO, wrapping the pointers
      base = pulse_cnt;
      for (int i = 0; i < 40; i++) push(8'(i * 37 + 5));
      wait_pulses(base + 40, 800);
      chk("wrap_left", exp_q.size(), 0);
      chk("wrap_level", {27'h0, level}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
